// File: rtl/fl_m32_reg_arb_pkg.sv
// rtl/fl_m32_reg_arb_pkg.sv - shared types and constants for the register port arbiter
package fl_m32_reg_arb_pkg;

    localparam int REG_DW = 512;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    // status_o field positions
    localparam int ST_TMO_LSB    = 0;
    localparam int ST_LATE_LSB   = 8;
    localparam int ST_IDX_LSB    = 16;
    localparam int ST_RDWAIT_BIT = 24;

endpackage

// File: rtl/fl_m32_rr_picker.sv
// rtl/fl_m32_rr_picker.sv - combinational round-robin picker starting after the pointer
module fl_m32_rr_picker #(
    parameter  int NUM_CORES = 4,
    localparam int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_CORES-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 vld_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_CORES);
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/fl_m32_reg_port_arbiter.sv
// rtl/fl_m32_reg_port_arbiter.sv - round-robin arbiter sharing one 512-bit register port between cores
module fl_m32_reg_port_arbiter
    import fl_m32_reg_arb_pkg::*;
#(
    parameter  int NUM_CORES   = 4,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int IDX_W       = $clog2(NUM_CORES)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_CORES-1:0]        req_rd_i,
    input  logic [NUM_CORES-1:0]        req_wr_i,
    input  logic [NUM_CORES-1:0]        req_wr_desp_i,
    input  logic [NUM_CORES*32-1:0]     req_addr_i,
    input  logic [NUM_CORES*REG_DW-1:0] req_wdata_i,
    output logic [NUM_CORES-1:0]        req_gnt_o,
    output logic [NUM_CORES-1:0]        req_rvalid_o,
    output logic [NUM_CORES-1:0]        req_rvalid_desp_o,
    output logic [NUM_CORES-1:0]        req_rerr_o,
    output logic [REG_DW-1:0]           req_rdata_o,
    output logic                        reg_rd_o,
    output logic [31:0]                 reg_raddr_o,
    input  logic [REG_DW-1:0]           reg_rdata_i,
    input  logic                        reg_rvalid_i,
    input  logic                        reg_rvalid_desp_i,
    output logic                        reg_wr_o,
    output logic                        reg_wr_desp_o,
    output logic [31:0]                 reg_waddr_o,
    output logic [REG_DW-1:0]           reg_wdata_o,
    output logic [31:0]                 status_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, owner_q, last_idx_q;
    logic [WD_W-1:0]  wdog_q;
    logic [7:0]       tmo_cnt_q, late_cnt_q;
    logic             rd_q, wr_q, wr_desp_q;
    logic [31:0]      raddr_q, waddr_q;
    logic [REG_DW-1:0] wdata_q;

    logic [31:0]       addr_arr  [NUM_CORES];
    logic [REG_DW-1:0] wdata_arr [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr_i[32*i +: 32];
        assign wdata_arr[i] = req_wdata_i[REG_DW*i +: REG_DW];
    end

    logic [NUM_CORES-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;

    fl_m32_rr_picker #(.NUM_CORES(NUM_CORES)) u_picker (
        .req_i (req_rd_i | req_wr_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    logic in_wait, rsp_any, grant_en, grant_wr, timeout_hit;

    // Grant is gated by rst_ni so outputs read as zero while reset is held.
    assign in_wait     = (state_q == RD_WAIT);
    assign rsp_any     = reg_rvalid_i | reg_rvalid_desp_i;
    assign grant_en    = rst_ni && (state_q == IDLE) && pick_vld;
    assign grant_wr    = req_wr_i[pick_idx];
    assign timeout_hit = in_wait && (wdog_q == WD_LAST) && !rsp_any;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_en && !grant_wr) state_d = RD_WAIT;
            RD_WAIT: if (rsp_any || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_gnt_o         = grant_en ? pick_gnt : '0;
        req_rvalid_o      = '0;
        req_rvalid_desp_o = '0;
        req_rerr_o        = '0;
        req_rdata_o       = '0;
        if (in_wait) begin
            req_rvalid_o[owner_q]      = reg_rvalid_i;
            req_rvalid_desp_o[owner_q] = reg_rvalid_desp_i;
            req_rerr_o[owner_q]        = timeout_hit;
            req_rdata_o                = reg_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(NUM_CORES - 1);
            owner_q    <= '0;
            last_idx_q <= '0;
            wdog_q     <= '0;
            tmo_cnt_q  <= '0;
            late_cnt_q <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wr_desp_q  <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= grant_en && !grant_wr;
            wr_q      <= grant_en && grant_wr;
            wr_desp_q <= grant_en && grant_wr && req_wr_desp_i[pick_idx];
            wdog_q    <= in_wait ? wdog_q + 1'b1 : '0;
            if (grant_en) begin
                ptr_q      <= pick_idx;
                last_idx_q <= pick_idx;
                if (grant_wr) begin
                    waddr_q <= addr_arr[pick_idx];
                    wdata_q <= wdata_arr[pick_idx];
                end else begin
                    raddr_q <= addr_arr[pick_idx];
                    owner_q <= pick_idx;
                end
            end
            if (timeout_hit && tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
            // Responses with no read outstanding are counted and dropped.
            if (!in_wait && rsp_any && late_cnt_q != 8'hFF) late_cnt_q <= late_cnt_q + 8'd1;
        end
    end

    assign reg_rd_o      = rd_q;
    assign reg_raddr_o   = raddr_q;
    assign reg_wr_o      = wr_q;
    assign reg_wr_desp_o = wr_desp_q;
    assign reg_waddr_o   = waddr_q;
    assign reg_wdata_o   = wdata_q;

    always_comb begin
        status_o                          = '0;
        status_o[ST_TMO_LSB +: 8]         = tmo_cnt_q;
        status_o[ST_LATE_LSB +: 8]        = late_cnt_q;
        status_o[ST_IDX_LSB +: 3]         = 3'(last_idx_q);
        status_o[ST_RDWAIT_BIT]           = in_wait;
    end

endmodule

// File: tb/tb_fl_m32_reg_port_arbiter.sv
// tb/tb_fl_m32_reg_port_arbiter.sv - directed self-checking bench for the register port arbiter
module tb_fl_m32_reg_port_arbiter;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [3:0]    req_rd_i, req_wr_i, req_wr_desp_i;
    logic [127:0]  req_addr_i;
    logic [2047:0] req_wdata_i;
    logic [3:0]    req_gnt_o, req_rvalid_o, req_rvalid_desp_o, req_rerr_o;
    logic [511:0]  req_rdata_o, reg_rdata_i, reg_wdata_o;
    logic          reg_rd_o, reg_rvalid_i, reg_rvalid_desp_i, reg_wr_o, reg_wr_desp_o;
    logic [31:0]   reg_raddr_o, reg_waddr_o, status_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    fl_m32_reg_port_arbiter #(.NUM_CORES(4), .TIMEOUT_CYC(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_rd_i(req_rd_i), .req_wr_i(req_wr_i), .req_wr_desp_i(req_wr_desp_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_gnt_o(req_gnt_o), .req_rvalid_o(req_rvalid_o),
        .req_rvalid_desp_o(req_rvalid_desp_o), .req_rerr_o(req_rerr_o),
        .req_rdata_o(req_rdata_o), .reg_rd_o(reg_rd_o), .reg_raddr_o(reg_raddr_o),
        .reg_rdata_i(reg_rdata_i), .reg_rvalid_i(reg_rvalid_i),
        .reg_rvalid_desp_i(reg_rvalid_desp_i), .reg_wr_o(reg_wr_o),
        .reg_wr_desp_o(reg_wr_desp_o), .reg_waddr_o(reg_waddr_o),
        .reg_wdata_o(reg_wdata_o), .status_o(status_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_rd_i = '0; req_wr_i = 4'b1111; req_wr_desp_i = '0;
        reg_rdata_i = '0; reg_rvalid_i = 1'b0; reg_rvalid_desp_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr_i[32*i +: 32]    = 32'h1000 + 32'(i) * 32'h10;
            req_wdata_i[512*i +: 512] = {16{32'hC0DE0000 + 32'(i)}};
        end
        step(); step();
        if (req_gnt_o !== 4'b0) begin n_fail++; $display("FAIL rst_gnt: got %b exp 0000", req_gnt_o); end
        n_tests++;
        if ({reg_wr_o, reg_rd_o, reg_wr_desp_o} !== 3'b0) begin n_fail++; $display("FAIL rst_strobes: got %b exp 000", {reg_wr_o, reg_rd_o, reg_wr_desp_o}); end
        n_tests++;
        if (status_o !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h exp 0", status_o); end
        n_tests++;
        if (reg_waddr_o !== 32'h0 || reg_raddr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h/%h exp 0/0", reg_waddr_o, reg_raddr_o); end
        n_tests++;
        req_wr_i = '0;
        rst_ni = 1'b1;
    endtask

    task automatic test_write_burst();
        logic [511:0] exp_wd;
        req_wr_i = 4'b1111;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (req_gnt_o !== 4'(1 << k)) begin n_fail++; $display("FAIL wr_gnt%0d: got %b exp %b", k, req_gnt_o, 4'(1 << k)); end
            n_tests++;
            step();
            exp_wd = {16{32'hC0DE0000 + 32'(k)}};
            if (reg_wr_o !== 1'b1 || reg_waddr_o !== 32'h1000 + 32'(k) * 32'h10) begin
                n_fail++; $display("FAIL wr_port%0d: got wr=%b addr=%h exp wr=1 addr=%h", k, reg_wr_o, reg_waddr_o, 32'h1000 + 32'(k) * 32'h10);
            end
            n_tests++;
            if (reg_wdata_o !== exp_wd) begin n_fail++; $display("FAIL wr_data%0d: got %h exp %h", k, reg_wdata_o[31:0], exp_wd[31:0]); end
            n_tests++;
            req_wr_i[k] = 1'b0;
            #1;
        end
        step();
        if (reg_wr_o !== 1'b0) begin n_fail++; $display("FAIL wr_end: got %b exp 0", reg_wr_o); end
        n_tests++;
        if (status_o[18:16] !== 3'd3) begin n_fail++; $display("FAIL wr_lastidx: got %0d exp 3", status_o[18:16]); end
        n_tests++;
    endtask

    task automatic test_read_route();
        req_addr_i[64 +: 32] = 32'h40;
        req_rd_i[2] = 1'b1;
        #1;
        if (req_gnt_o !== 4'b0100) begin n_fail++; $display("FAIL rd_gnt: got %b exp 0100", req_gnt_o); end
        n_tests++;
        step();
        req_rd_i[2] = 1'b0;
        req_rd_i[0] = 1'b1;
        if (reg_rd_o !== 1'b1 || reg_raddr_o !== 32'h40 || status_o[24] !== 1'b1) begin
            n_fail++; $display("FAIL rd_issue: got rd=%b addr=%h wait=%b exp 1/00000040/1", reg_rd_o, reg_raddr_o, status_o[24]);
        end
        n_tests++;
        for (int j = 1; j <= 4; j++) begin
            step();
            #1;
            if ({req_gnt_o, req_rvalid_o, reg_rd_o} !== 9'b0) begin
                n_fail++; $display("FAIL rd_wait%0d: got gnt=%b rv=%b rd=%b exp 0", j, req_gnt_o, req_rvalid_o, reg_rd_o);
            end
            n_tests++;
        end
        step();
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = {16{32'hA5A5A5A5}};
        #1;
        if (req_rvalid_o !== 4'b0100 || req_gnt_o !== 4'b0) begin n_fail++; $display("FAIL rd_rvalid: got rv=%b gnt=%b exp 0100/0000", req_rvalid_o, req_gnt_o); end
        n_tests++;
        if (req_rdata_o !== {16{32'hA5A5A5A5}}) begin n_fail++; $display("FAIL rd_rdata: got %h exp a5a5a5a5", req_rdata_o[31:0]); end
        n_tests++;
        step();
        reg_rvalid_i = 1'b0;
        #1;
        if (req_gnt_o !== 4'b0001) begin n_fail++; $display("FAIL rd_next_gnt: got %b exp 0001", req_gnt_o); end
        n_tests++;
        step();
        req_rd_i[0] = 1'b0;
        if (reg_rd_o !== 1'b1 || reg_raddr_o !== 32'h1000) begin n_fail++; $display("FAIL rd0_issue: got rd=%b addr=%h exp 1/00001000", reg_rd_o, reg_raddr_o); end
        n_tests++;
        reg_rvalid_desp_i = 1'b1;
        #1;
        if (req_rvalid_desp_o !== 4'b0001 || req_rvalid_o !== 4'b0) begin n_fail++; $display("FAIL rd0_desp: got desp=%b rv=%b exp 0001/0000", req_rvalid_desp_o, req_rvalid_o); end
        n_tests++;
        step();
        reg_rvalid_desp_i = 1'b0;
        if (status_o[24] !== 1'b0 || status_o[15:8] !== 8'd0) begin n_fail++; $display("FAIL rd0_done: got wait=%b late=%0d exp 0/0", status_o[24], status_o[15:8]); end
        n_tests++;
    endtask

    task automatic test_rd_wr_mix();
        req_rd_i[1] = 1'b1; req_wr_i[1] = 1'b1; req_wr_i[3] = 1'b1;
        #1;
        if (req_gnt_o !== 4'b0010) begin n_fail++; $display("FAIL mix_gnt1w: got %b exp 0010", req_gnt_o); end
        n_tests++;
        step();
        req_wr_i[1] = 1'b0;
        #1;
        if (reg_wr_o !== 1'b1 || reg_waddr_o !== 32'h1010) begin n_fail++; $display("FAIL mix_wr1: got wr=%b addr=%h exp 1/00001010", reg_wr_o, reg_waddr_o); end
        n_tests++;
        if (req_gnt_o !== 4'b1000) begin n_fail++; $display("FAIL mix_gnt3w: got %b exp 1000", req_gnt_o); end
        n_tests++;
        step();
        req_wr_i[3] = 1'b0;
        #1;
        if (reg_wr_o !== 1'b1 || reg_waddr_o !== 32'h1030) begin n_fail++; $display("FAIL mix_wr3: got wr=%b addr=%h exp 1/00001030", reg_wr_o, reg_waddr_o); end
        n_tests++;
        if (req_gnt_o !== 4'b0010) begin n_fail++; $display("FAIL mix_gnt1r: got %b exp 0010", req_gnt_o); end
        n_tests++;
        step();
        req_rd_i[1] = 1'b0;
        if (reg_rd_o !== 1'b1 || reg_wr_o !== 1'b0 || reg_raddr_o !== 32'h1010) begin
            n_fail++; $display("FAIL mix_rd1: got rd=%b wr=%b addr=%h exp 1/0/00001010", reg_rd_o, reg_wr_o, reg_raddr_o);
        end
        n_tests++;
    endtask

    task automatic test_timeout();
        for (int j = 2; j <= 7; j++) begin
            step();
            if (req_rerr_o !== 4'b0) begin n_fail++; $display("FAIL tmo_early%0d: got %b exp 0000", j, req_rerr_o); end
            n_tests++;
        end
        step();
        if (req_rerr_o !== 4'b0010 || status_o[24] !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got err=%b wait=%b exp 0010/1", req_rerr_o, status_o[24]); end
        n_tests++;
        step();
        if (req_rerr_o !== 4'b0 || status_o[7:0] !== 8'd1 || status_o[24] !== 1'b0) begin
            n_fail++; $display("FAIL tmo_after: got err=%b cnt=%0d wait=%b exp 0000/1/0", req_rerr_o, status_o[7:0], status_o[24]);
        end
        n_tests++;
        step();
        reg_rvalid_i = 1'b1;
        #1;
        if (req_rvalid_o !== 4'b0) begin n_fail++; $display("FAIL late_fwd: got %b exp 0000", req_rvalid_o); end
        n_tests++;
        step();
        reg_rvalid_i = 1'b0;
        if (status_o[15:8] !== 8'd1) begin n_fail++; $display("FAIL late_cnt: got %0d exp 1", status_o[15:8]); end
        n_tests++;
    endtask

    task automatic test_timeout_race();
        req_rd_i[2] = 1'b1;
        #1;
        if (req_gnt_o !== 4'b0100) begin n_fail++; $display("FAIL race_gnt: got %b exp 0100", req_gnt_o); end
        n_tests++;
        step();
        req_rd_i[2] = 1'b0;
        for (int j = 2; j <= 7; j++) step();
        step();
        reg_rvalid_i = 1'b1; reg_rvalid_desp_i = 1'b1;
        reg_rdata_i  = {16{32'h5A5A0F0F}};
        #1;
        if (req_rvalid_o !== 4'b0100 || req_rvalid_desp_o !== 4'b0100 || req_rerr_o !== 4'b0) begin
            n_fail++; $display("FAIL race_fwd: got rv=%b desp=%b err=%b exp 0100/0100/0000", req_rvalid_o, req_rvalid_desp_o, req_rerr_o);
        end
        n_tests++;
        if (req_rdata_o !== {16{32'h5A5A0F0F}}) begin n_fail++; $display("FAIL race_data: got %h exp 5a5a0f0f", req_rdata_o[31:0]); end
        n_tests++;
        step();
        reg_rvalid_i = 1'b0; reg_rvalid_desp_i = 1'b0;
        if (status_o[7:0] !== 8'd1 || status_o[15:8] !== 8'd1 || status_o[24] !== 1'b0) begin
            n_fail++; $display("FAIL race_status: got tmo=%0d late=%0d wait=%b exp 1/1/0", status_o[7:0], status_o[15:8], status_o[24]);
        end
        n_tests++;
    endtask

    task automatic test_reset_mid_read();
        req_rd_i[3] = 1'b1;
        #1;
        if (req_gnt_o !== 4'b1000) begin n_fail++; $display("FAIL mrst_gnt: got %b exp 1000", req_gnt_o); end
        n_tests++;
        step();
        req_rd_i[3] = 1'b0;
        req_wr_i = 4'b1111;
        if (status_o[24] !== 1'b1 || reg_rd_o !== 1'b1) begin n_fail++; $display("FAIL mrst_wait: got wait=%b rd=%b exp 1/1", status_o[24], reg_rd_o); end
        n_tests++;
        #1;
        rst_ni = 1'b0;
        #1;
        if ({req_gnt_o, reg_rd_o, reg_wr_o, req_rvalid_o, req_rerr_o} !== 14'b0 || status_o !== 32'h0) begin
            n_fail++; $display("FAIL mrst_outs: got gnt=%b rd=%b wr=%b status=%h exp all 0", req_gnt_o, reg_rd_o, reg_wr_o, status_o);
        end
        n_tests++;
        if (reg_raddr_o !== 32'h0 || reg_waddr_o !== 32'h0 || reg_wdata_o !== 512'h0) begin
            n_fail++; $display("FAIL mrst_data: got raddr=%h waddr=%h exp 0/0", reg_raddr_o, reg_waddr_o);
        end
        n_tests++;
        step(); step();
        rst_ni = 1'b1;
        reg_rvalid_i = 1'b1;
        #1;
        if (req_gnt_o !== 4'b0001 || req_rvalid_o !== 4'b0) begin n_fail++; $display("FAIL mrst_first: got gnt=%b rv=%b exp 0001/0000", req_gnt_o, req_rvalid_o); end
        n_tests++;
        step();
        reg_rvalid_i = 1'b0;
        req_wr_i = '0;
        if (status_o[15:8] !== 8'd1 || status_o[18:16] !== 3'd0 || reg_wr_o !== 1'b1 || reg_waddr_o !== 32'h1000) begin
            n_fail++; $display("FAIL mrst_after: got late=%0d idx=%0d wr=%b addr=%h exp 1/0/1/00001000", status_o[15:8], status_o[18:16], reg_wr_o, reg_waddr_o);
        end
        n_tests++;
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: got simulation still running exp finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        test_reset();
        test_write_burst();
        test_read_route();
        test_rd_wr_mix();
        test_timeout();
        test_timeout_race();
        test_reset_mid_read();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fl_m32_reg_port_arbiter.md
Name: fl_m32_reg_port_arbiter

Overview:
- Shares one 512-bit register/descriptor access port between NUM_CORES cv32e40p core instances.
- That port is the reg_rd/reg_wr/reg_rvalid/reg_rvalid_desp interface each core drives.
- Arbitration is round-robin. At most one read is outstanding at a time, and the arbiter routes each read response back to the core that issued it.
- A watchdog detects a read with no response, so a requesting core cannot wedge the shared port.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- TIMEOUT_CYC, 1024, cycles in RD_WAIT before the read is aborted with an error (≥2).
- IDX_W, $clog2(NUM_CORES), width of the requester index (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_rd_i  in  NUM_CORES  per-core read request; held until its gnt.
- req_wr_i  in  NUM_CORES  per-core write request; held until its gnt.
- req_wr_desp_i  in  NUM_CORES  write targets the descriptor space (qualifies req_wr_i).
- req_addr_i  in  NUM_CORES*32  per-core address, slice i = [32*i+:32].
- req_wdata_i  in  NUM_CORES*512  per-core write data, slice i = [512*i+:512].
- req_gnt_o  out  NUM_CORES  one-hot grant pulse.
- req_rvalid_o  out  NUM_CORES  read data valid, routed to the owner.
- req_rvalid_desp_o  out  NUM_CORES  descriptor read valid, routed to the owner.
- req_rerr_o  out  NUM_CORES  read timeout error pulse to the owner.
- req_rdata_o  out  512  read data, broadcast to all cores.
- reg_rd_o  out  1  shared-port read strobe.
- reg_raddr_o  out  32  shared-port read address.
- reg_rdata_i  in  512  shared-port read data.
- reg_rvalid_i  in  1  shared-port read response.
- reg_rvalid_desp_i  in  1  shared-port descriptor read response.
- reg_wr_o  out  1  shared-port write strobe.
- reg_wr_desp_o  out  1  shared-port descriptor write qualifier.
- reg_waddr_o  out  32  shared-port write address.
- reg_wdata_o  out  512  shared-port write data.
- status_o  out  32  status word: [7:0] timeout count (saturating at 255); [15:8] late-response count (saturating at 255); [18:16] last granted index; [24] FSM is in RD_WAIT.

Behaviour:
- Reset, asserted asynchronously:
  - all outputs are 0;
  - FSM goes to IDLE;
  - the round-robin pointer is NUM_CORES-1, so core 0 wins first;
  - the watchdog counter and the status counters are 0.
- Eligibility: core i is eligible when req_rd_i[i] | req_wr_i[i].
  - If a core asserts both, its write is served first. Its read stays pending.
- IDLE state:
  - Search order starts at pointer+1 and wraps modulo NUM_CORES.
  - The first eligible core w gets req_gnt_o[w]=1 in the same cycle, combinationally.
  - On that grant the pointer becomes w.
- Write grant:
  - The next cycle drives reg_wr_o=1, reg_wr_desp_o, reg_waddr_o and reg_wdata_o from core w's registered values.
  - reg_wr_o is high for exactly one cycle.
  - FSM stays in IDLE, so back-to-back writes are sustained at one per cycle.
- Read grant:
  - The next cycle drives reg_rd_o=1 for exactly one cycle, with reg_raddr_o registered from core w.
  - The owner index is registered.
  - FSM goes to RD_WAIT.
- RD_WAIT state:
  - No grants are issued.
  - The watchdog increments every cycle.
  - req_rdata_o = reg_rdata_i, combinational pass-through.
  - req_rvalid_o[owner] = reg_rvalid_i and req_rvalid_desp_o[owner] = reg_rvalid_desp_i, in the same cycle as the response.
  - If both responses arrive in the same cycle, both are forwarded.
  - On either response, FSM returns to IDLE at the next edge. The earliest new grant is the cycle after the response.
- Timeout:
  - When the watchdog reaches TIMEOUT_CYC-1 with no response, req_rerr_o[owner] pulses for one cycle and the timeout count increments.
  - FSM returns to IDLE.
  - A response arriving in that same cycle wins: it is forwarded with no error.
- Late response: reg_rvalid_i or reg_rvalid_desp_i arriving in IDLE is dropped, not forwarded, and the late-response count increments.
- Idle output values:
  - address and wdata outputs hold their last values;
  - strobes are 0;
  - req_rvalid_o, req_rvalid_desp_o and req_rerr_o are 0 outside RD_WAIT.
- Dropped request: a request deasserted before grant is simply not served. No error is raised.
- Reset mid-read: the outstanding read is forgotten, and a subsequent response is treated as late.

Decomposition:
- Shared package fl_m32_reg_arb_pkg holds:
  - the FSM enum arb_state_e {IDLE, RD_WAIT};
  - status bit-position constants;
  - the 512-bit data width constant REG_DW.
- One sub-module, fl_m32_rr_picker:
  - parameterised by NUM_CORES;
  - inputs are the request vector and the pointer;
  - outputs are a one-hot grant and the encoded index;
  - it is purely combinational, with the pointer register held in the parent.

Test Plan:
- Cores 0..3 all assert req_wr_i at once from reset → grants go to 0,1,2,3 on consecutive cycles; reg_wr_o is high 4 consecutive cycles with matching reg_waddr_o; status_o[18:16]=3.
- Core 2 reads addr 0x40 and reg_rvalid_i returns 5 cycles after reg_rd_o with data 0xA5…A5 → req_rvalid_o=4'b0100 in that cycle with req_rdata_o=0xA5…A5; no other grant during the wait.
- Core 1 asserts rd+wr together while core 3 asserts wr → grant order is core1 write, core3 write, core1 read.
- Read with no response, TIMEOUT_CYC=8 → req_rerr_o[owner] pulses 8 cycles after the read grant; status_o[7:0]=1; a reg_rvalid_i injected 2 cycles later gives status_o[15:8]=1 and no req_rvalid_o.
- reg_rvalid_i and reg_rvalid_desp_i together in the timeout cycle → both forwarded, no req_rerr_o, timeout count unchanged.
- rst_ni dropped during RD_WAIT → all outputs 0 immediately; after release core 0 wins the first contention.
